// File: rtl/dp_iso_lane_scrambler.sv
// Four-lane DisplayPort main-link scrambler: per-lane 16-bit Galois LFSR keys data symbols,
// control symbols pass through, SR reseeds its own lane; one registered pipeline stage.
module dp_iso_lane_scrambler #(
  parameter int                        AUX_DATA_WIDTH = 8,
  parameter logic [AUX_DATA_WIDTH-1:0] SR_CODE        = 8'h1C,
  parameter logic [15:0]               LFSR_SEED      = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scramble_en,
  input  logic [2:0]                lane_count,
  input  logic                      sym_valid,
  input  logic [AUX_DATA_WIDTH-1:0] iso_symbols_lane0,
  input  logic [AUX_DATA_WIDTH-1:0] iso_symbols_lane1,
  input  logic [AUX_DATA_WIDTH-1:0] iso_symbols_lane2,
  input  logic [AUX_DATA_WIDTH-1:0] iso_symbols_lane3,
  input  logic                      control_sym_flag_lane0,
  input  logic                      control_sym_flag_lane1,
  input  logic                      control_sym_flag_lane2,
  input  logic                      control_sym_flag_lane3,
  output logic                      scr_valid,
  output logic [AUX_DATA_WIDTH-1:0] scr_symbols_lane0,
  output logic [AUX_DATA_WIDTH-1:0] scr_symbols_lane1,
  output logic [AUX_DATA_WIDTH-1:0] scr_symbols_lane2,
  output logic [AUX_DATA_WIDTH-1:0] scr_symbols_lane3,
  output logic                      scr_control_sym_flag_lane0,
  output logic                      scr_control_sym_flag_lane1,
  output logic                      scr_control_sym_flag_lane2,
  output logic                      scr_control_sym_flag_lane3
);

  // Eight LSB-first Galois steps of x^16+x^5+x^4+x^3+1; returns {key_byte, next_state}.
  function automatic logic [23:0] lfsr_adv8(input logic [15:0] state);
    logic [15:0] s;
    logic [7:0]  k;
    s = state;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[15];
      s    = {s[14:0], s[15]} ^ (s[15] ? 16'h0038 : 16'h0000);
    end
    return {k, s};
  endfunction

  logic [AUX_DATA_WIDTH-1:0] w_in       [4];
  logic                      w_flag_in  [4];
  logic [3:0]                w_active;
  logic [15:0]               r_lfsr     [4];
  logic [15:0]               w_lfsr_nxt [4];
  logic [AUX_DATA_WIDTH-1:0] r_sym      [4];
  logic [AUX_DATA_WIDTH-1:0] w_sym_nxt  [4];
  logic                      r_flag     [4];
  logic                      w_flag_nxt [4];
  logic                      r_valid;

  // Lane gathering and active-lane mask; unsupported counts fall back to four lanes.
  always_comb begin
    w_in[0]      = iso_symbols_lane0;
    w_in[1]      = iso_symbols_lane1;
    w_in[2]      = iso_symbols_lane2;
    w_in[3]      = iso_symbols_lane3;
    w_flag_in[0] = control_sym_flag_lane0;
    w_flag_in[1] = control_sym_flag_lane1;
    w_flag_in[2] = control_sym_flag_lane2;
    w_flag_in[3] = control_sym_flag_lane3;
    case (lane_count)
      3'd1:    w_active = 4'b0001;
      3'd2:    w_active = 4'b0011;
      default: w_active = 4'b1111;
    endcase
  end

  // Per-lane next-state: inactive and bypassed lanes sit at the seed, SR reseeds.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      logic [23:0] w_adv;
      w_adv         = lfsr_adv8(r_lfsr[n]);
      w_lfsr_nxt[n] = r_lfsr[n];
      w_sym_nxt[n]  = r_sym[n];
      w_flag_nxt[n] = r_flag[n];
      if (sym_valid) begin
        if (!w_active[n]) begin
          w_lfsr_nxt[n] = LFSR_SEED;
          w_sym_nxt[n]  = '0;
          w_flag_nxt[n] = 1'b0;
        end else if (!scramble_en) begin
          w_lfsr_nxt[n] = LFSR_SEED;
          w_sym_nxt[n]  = w_in[n];
          w_flag_nxt[n] = w_flag_in[n];
        end else if (w_flag_in[n] && (w_in[n] == SR_CODE)) begin
          w_lfsr_nxt[n] = LFSR_SEED;
          w_sym_nxt[n]  = w_in[n];
          w_flag_nxt[n] = 1'b1;
        end else if (w_flag_in[n]) begin
          w_lfsr_nxt[n] = w_adv[15:0];
          w_sym_nxt[n]  = w_in[n];
          w_flag_nxt[n] = 1'b1;
        end else begin
          w_lfsr_nxt[n] = w_adv[15:0];
          w_sym_nxt[n]  = w_in[n] ^ AUX_DATA_WIDTH'(w_adv[23:16]);
          w_flag_nxt[n] = 1'b0;
        end
      end else begin
        w_lfsr_nxt[n] = r_lfsr[n];
      end
    end
  end

  // Pipeline and LFSR state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        r_lfsr[n] <= LFSR_SEED;
        r_sym[n]  <= '0;
        r_flag[n] <= 1'b0;
      end
    end else begin
      r_valid <= sym_valid;
      for (int n = 0; n < 4; n++) begin
        r_lfsr[n] <= w_lfsr_nxt[n];
        r_sym[n]  <= w_sym_nxt[n];
        r_flag[n] <= w_flag_nxt[n];
      end
    end
  end

  assign scr_valid                  = r_valid;
  assign scr_symbols_lane0          = r_sym[0];
  assign scr_symbols_lane1          = r_sym[1];
  assign scr_symbols_lane2          = r_sym[2];
  assign scr_symbols_lane3          = r_sym[3];
  assign scr_control_sym_flag_lane0 = r_flag[0];
  assign scr_control_sym_flag_lane1 = r_flag[1];
  assign scr_control_sym_flag_lane2 = r_flag[2];
  assign scr_control_sym_flag_lane3 = r_flag[3];

endmodule
